tour_move_scheduler: RTL and testbench
======================================

Name: tour_move_scheduler

Overview:
- Sits between the UART command path, the tour solver's move memory and the command processor.
- In IDLE it passes UART commands straight through to the command processor.
- When a tour is started, it walks the solved move list and splits each knight move into two MOVE commands: vertical first without fanfare, then horizontal with fanfare.
- Drives the 8-bit response: 0x5A while intermediate moves are in progress, 0xA5 when the tour is complete.

Parameters:
- NUM_MOVES, 24, number of moves in a full 5x5 tour.
- IDX_W, 5, width of mv_indx.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_tour  in  1  one-cycle pulse from the solver; solution memory is valid.
- move  in  8  one-hot move read combinationally from the solver memory at mv_indx.
- mv_indx  out  IDX_W  index of the current move.
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy_UART  out  1  acknowledge to the UART wrapper.
- cmd  out  16  command to the command processor.
- cmd_rdy  out  1  command valid to the command processor.
- clr_cmd_rdy  in  1  command processor has accepted cmd.
- send_resp  in  1  command processor finished executing cmd.
- resp  out  8  response byte to the UART transmitter.
- tour_busy  out  1  high while the scheduler owns the command processor.

Behaviour:
- Reset values: state IDLE, mv_indx 0, tour_busy 0, cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART 0, resp 0xA5.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H. State and mv_indx are registered; all outputs decode combinationally from state, mv_indx and move.
- IDLE:
  - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy.
  - start_tour -> mv_indx <= 0, go to VERT.
- VERT:
  - cmd = {4'b0010, hdgV, cntV}, cmd_rdy = 1.
  - clr_cmd_rdy -> WAIT_V.
- WAIT_V: cmd_rdy = 0; send_resp -> HORZ.
- HORZ:
  - cmd = {4'b0011, hdgH, cntH}, cmd_rdy = 1.
  - clr_cmd_rdy -> WAIT_H.
- WAIT_H: on send_resp:
  - if mv_indx == NUM_MOVES-1 -> IDLE, mv_indx <= 0.
  - else mv_indx <= mv_indx+1 -> VERT.
- Headings: NORTH 8'h00, WEST 8'h3F, SOUTH 8'h7F, EAST 8'hBF.
- Move decode uses priority on the lowest set bit; move == 0 decodes as bit 7. Each bit gives (dx, dy):
  - bit0 (-1,+2); bit1 (+1,+2); bit2 (-2,+1); bit3 (-2,-1)
  - bit4 (-1,-2); bit5 (+1,-2); bit6 (+2,-1); bit7 (+2,+1)
- Vertical command: hdgV = NORTH if dy > 0, else SOUTH; cntV = |dy|.
- Horizontal command: hdgH = EAST if dx > 0, else WEST; cntH = |dx|. Counts are zero-extended to 4 bits.
- resp:
  - 0xA5 in IDLE, and in WAIT_H when mv_indx == NUM_MOVES-1.
  - 0x5A in all other tour states.
  - resp must be valid in the cycle send_resp is high.
- tour_busy = (state != IDLE).
- Ownership rules while tour_busy:
  - UART commands are not forwarded and clr_cmd_rdy_UART = 0.
  - A pending cmd_rdy_UART is held off until IDLE, then forwarded.
- start_tour outside IDLE is ignored.
- clr_cmd_rdy and send_resp outside their waiting states are ignored.
- Simultaneous start_tour and cmd_rdy_UART in IDLE: start_tour wins. The UART command is not acknowledged that cycle and stays pending.
- Latency: cmd_rdy rises one clock after start_tour, and one clock after each send_resp that advances the tour.
- Reset asserted mid-tour: immediately returns to IDLE, mv_indx 0, cmd_rdy follows cmd_rdy_UART.

Decomposition:
- Add to the shared package:
  - a heading typedef or constants NORTH, WEST, SOUTH, EAST;
  - RESP_DONE 8'hA5 and RESP_INTER 8'h5A;
  - opcode constants MOVE 4'b0010 and MOVE_FANFARE 4'b0011;
  - a state enum.
- One natural sub-module: knight_move_decode, combinational, mapping move[7:0] to {hdgV, cntV, hdgH, cntH}.

Test Plan:
1. IDLE passthrough: cmd_UART = 16'h2002 with cmd_rdy_UART = 1 -> cmd = 16'h2002, cmd_rdy = 1; clr_cmd_rdy pulse -> clr_cmd_rdy_UART pulses; resp = 0xA5.
2. move = 8'h02 at index 0, then start_tour:
   - next cycle cmd = 16'h2002, cmd_rdy = 1;
   - after clr and send_resp: cmd = 16'h3BF1, resp = 0x5A.
3. move = 8'h08 -> cmd 16'h27F1 then 16'h33F2. move = 8'h40 -> cmd 16'h27F1 then 16'h3BF2.
4. Full 24-move tour with an emulated command processor:
   - exactly 48 cmd_rdy handshakes;
   - mv_indx runs 0..23;
   - final send_resp sees resp = 0xA5, then tour_busy = 0.
5. cmd_rdy_UART = 1 during tour -> clr_cmd_rdy_UART stays 0 and cmd is not cmd_UART; after the tour completes the UART command is forwarded.
6. rst_n low in WAIT_H at mv_indx 7 -> state IDLE, mv_indx 0, tour_busy 0 without waiting for a clock edge; a new start_tour restarts from index 0.

Source files
------------

// File: rtl/tour_move_scheduler_pkg.sv
// Shared constants, state encoding and decoded-move record for the tour move scheduler.
package tour_move_scheduler_pkg;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_INTER = 8'h5A;

    localparam logic [3:0] MOVE         = 4'b0010;
    localparam logic [3:0] MOVE_FANFARE = 4'b0011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] hdg_v;
        logic [3:0] cnt_v;
        logic [7:0] hdg_h;
        logic [3:0] cnt_h;
    } move_cmd_t;

endpackage

// File: rtl/tour_move_scheduler_knight_move_decode.sv
// Maps a one-hot knight move to its vertical and horizontal heading/count pair.
module tour_move_scheduler_knight_move_decode
    import tour_move_scheduler_pkg::*;
(
    input  logic [7:0] move,
    output logic [7:0] hdg_v,
    output logic [3:0] cnt_v,
    output logic [7:0] hdg_h,
    output logic [3:0] cnt_h
);

    logic [2:0] sel;

    // Lowest set bit wins; an all-zero move falls through to bit 7.
    always_comb begin
        sel = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) sel = 3'(i);
        end
    end

    always_comb begin
        hdg_v = NORTH;
        cnt_v = 4'd1;
        hdg_h = EAST;
        cnt_h = 4'd2;
        case (sel)
            3'd0: begin hdg_v = NORTH; cnt_v = 4'd2; hdg_h = WEST; cnt_h = 4'd1; end
            3'd1: begin hdg_v = NORTH; cnt_v = 4'd2; hdg_h = EAST; cnt_h = 4'd1; end
            3'd2: begin hdg_v = NORTH; cnt_v = 4'd1; hdg_h = WEST; cnt_h = 4'd2; end
            3'd3: begin hdg_v = SOUTH; cnt_v = 4'd1; hdg_h = WEST; cnt_h = 4'd2; end
            3'd4: begin hdg_v = SOUTH; cnt_v = 4'd2; hdg_h = WEST; cnt_h = 4'd1; end
            3'd5: begin hdg_v = SOUTH; cnt_v = 4'd2; hdg_h = EAST; cnt_h = 4'd1; end
            3'd6: begin hdg_v = SOUTH; cnt_v = 4'd1; hdg_h = EAST; cnt_h = 4'd2; end
            default: begin hdg_v = NORTH; cnt_v = 4'd1; hdg_h = EAST; cnt_h = 4'd2; end
        endcase
    end

endmodule

// File: rtl/tour_move_scheduler.sv
// Walks the solved tour, splitting each knight move into a vertical MOVE and a
// horizontal MOVE_FANFARE; otherwise passes UART commands to the command processor.
module tour_move_scheduler
    import tour_move_scheduler_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic [2:0]       state_dbg
);

    // Handshake: cmd is offered while cmd_rdy is high and is taken in the cycle
    // clr_cmd_rdy is high; send_resp marks completion of the taken command.

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             last_move;
    move_cmd_t        mc;

    tour_move_scheduler_knight_move_decode u_decode (
        .move  (move),
        .hdg_v (mc.hdg_v),
        .cnt_v (mc.cnt_v),
        .hdg_h (mc.hdg_h),
        .cnt_h (mc.cnt_h)
    );

    assign last_move = (mv_indx == IDX_W'(NUM_MOVES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            state   <= state_nxt;
            mv_indx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = mv_indx;
        case (state)
            IDLE: if (start_tour) begin
                state_nxt = VERT;
                idx_nxt   = '0;
            end
            VERT:   if (clr_cmd_rdy) state_nxt = WAIT_V;
            WAIT_V: if (send_resp)   state_nxt = HORZ;
            HORZ:   if (clr_cmd_rdy) state_nxt = WAIT_H;
            WAIT_H: if (send_resp) begin
                if (last_move) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    state_nxt = VERT;
                    idx_nxt   = mv_indx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // A start_tour in the same cycle as a UART command leaves that command unacknowledged.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_INTER;
        case (state)
            IDLE: begin
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy & ~start_tour;
                resp             = RESP_DONE;
            end
            VERT: begin
                cmd     = {MOVE, mc.hdg_v, mc.cnt_v};
                cmd_rdy = 1'b1;
            end
            WAIT_V: cmd = {MOVE, mc.hdg_v, mc.cnt_v};
            HORZ: begin
                cmd     = {MOVE_FANFARE, mc.hdg_h, mc.cnt_h};
                cmd_rdy = 1'b1;
            end
            WAIT_H: begin
                cmd  = {MOVE_FANFARE, mc.hdg_h, mc.cnt_h};
                resp = last_move ? RESP_DONE : RESP_INTER;
            end
            default: resp = RESP_DONE;
        endcase
    end

    assign tour_busy = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tour_move_scheduler.sv
// Directed bench for tour_move_scheduler: passthrough, move decode, full tour, UART hold-off, reset abort.
module tb_tour_move_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tour_busy;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int uart_ack_busy = 0;
    int uart_fwd_busy = 0;

    logic [7:0]  move_mem [0:23];
    logic [15:0] exp_q [$];

    // Hand-computed commands per winning move bit.
    logic [15:0] exp_v [0:7] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                                 16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    logic [15:0] exp_h [0:7] = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2,
                                 16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};
    // Tour table: first 16 are single bits, last 8 exercise priority and the zero case.
    logic [7:0] tour_val [0:7] = '{8'h00, 8'hFF, 8'h0C, 8'h30, 8'hC0, 8'h82, 8'h88, 8'hA0};
    int         tour_bit [0:7] = '{7, 0, 2, 4, 6, 1, 3, 5};
    int         bit_of [0:23];

    tour_move_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .tour_busy        (tour_busy),
        .state_dbg        (state_dbg)
    );

    assign move = (mv_indx < 5'd24) ? move_mem[mv_indx] : 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (rst_n && tour_busy && cmd_rdy && clr_cmd_rdy) hs_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && tour_busy) begin
            if (clr_cmd_rdy_UART) uart_ack_busy++;
            if (cmd == cmd_UART)  uart_fwd_busy++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Emulated command processor: wait for cmd_rdy, accept, then respond.
    task automatic serve_cmd(input string tag, input logic [7:0] exp_resp,
                             input bit do_resp, output int waited);
        logic [15:0] exp_cmd;
        waited = 0;
        while (!cmd_rdy && waited < 20) begin
            tick();
            waited++;
        end
        exp_cmd = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_rdy"}, {31'd0, cmd_rdy}, 32'd1);
        check({tag, "_cmd"}, {16'd0, cmd}, {16'd0, exp_cmd});
        check({tag, "_resp_busy"}, {24'd0, resp}, 32'h5A);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check({tag, "_rdy_drop"}, {31'd0, cmd_rdy}, 32'd0);
        tick();
        if (do_resp) begin
            send_resp = 1'b1;
            #1;
            check({tag, "_resp"}, {24'd0, resp}, {24'd0, exp_resp});
            tick();
            send_resp = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    task automatic one_move_test(input string tag, input logic [7:0] mv,
                                 input logic [15:0] ev, input logic [15:0] eh);
        int w;
        move_mem[0] = mv;
        exp_q.push_back(ev);
        exp_q.push_back(eh);
        start();
        serve_cmd({tag, "_v"}, 8'h5A, 1'b1, w);
        check({tag, "_v_latency"}, w, 0);
        serve_cmd({tag, "_h"}, 8'h5A, 1'b1, w);
        check({tag, "_h_latency"}, w, 0);
        check({tag, "_idx_adv"}, {27'd0, mv_indx}, 32'd1);
        do_reset();
    endtask

    initial begin
        int w;
        int hs0;
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        for (int i = 0; i < 24; i++) move_mem[i] = 8'h00;
        #2;
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        check("rst_idx", {27'd0, mv_indx}, 32'd0);
        check("rst_busy", {31'd0, tour_busy}, 32'd0);
        check("rst_cmd", {16'd0, cmd}, 32'h1234);
        check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("rst_clr_uart", {31'd0, clr_cmd_rdy_UART}, 32'd0);
        check("rst_resp", {24'd0, resp}, 32'hA5);
        tick();
        rst_n = 1'b1;
        tick();

        // IDLE passthrough
        cmd_UART = 16'h2002;
        cmd_rdy_UART = 1'b1;
        #1;
        check("pt_cmd", {16'd0, cmd}, 32'h2002);
        check("pt_rdy", {31'd0, cmd_rdy}, 32'd1);
        clr_cmd_rdy = 1'b1;
        #1;
        check("pt_clr_uart", {31'd0, clr_cmd_rdy_UART}, 32'd1);
        check("pt_resp", {24'd0, resp}, 32'hA5);
        tick();
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
        #1;
        check("pt_clr_drop", {31'd0, clr_cmd_rdy_UART}, 32'd0);

        // start_tour wins over a simultaneous UART command
        move_mem[0] = 8'h02;
        exp_q.push_back(16'h2002);
        exp_q.push_back(16'h3BF1);
        cmd_UART = 16'h2BBB;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b1;
        start_tour = 1'b1;
        #1;
        check("race_no_ack", {31'd0, clr_cmd_rdy_UART}, 32'd0);
        tick();
        start_tour = 1'b0;
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
        check("t2_busy", {31'd0, tour_busy}, 32'd1);
        serve_cmd("t2_v", 8'h5A, 1'b1, w);
        check("t2_v_latency", w, 0);
        serve_cmd("t2_h", 8'h5A, 1'b1, w);
        check("t2_h_latency", w, 0);
        do_reset();

        one_move_test("t3_08", 8'h08, 16'h27F1, 16'h33F2);
        one_move_test("t3_40", 8'h40, 16'h27F1, 16'h3BF2);

        // Full tour with a UART command held pending throughout
        for (int i = 0; i < 24; i++) begin
            if (i < 16) begin
                move_mem[i] = 8'h01 << (i % 8);
                bit_of[i]   = i % 8;
            end else begin
                move_mem[i] = tour_val[i-16];
                bit_of[i]   = tour_bit[i-16];
            end
        end
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(exp_v[bit_of[i]]);
            exp_q.push_back(exp_h[bit_of[i]]);
        end
        hs0 = hs_cnt;
        uart_ack_busy = 0;
        uart_fwd_busy = 0;
        cmd_UART = 16'h5555;
        cmd_rdy_UART = 1'b1;
        start();
        for (int i = 0; i < 24; i++) begin
            check($sformatf("t4_idx%0d", i), {27'd0, mv_indx}, i);
            serve_cmd($sformatf("t4_v%0d", i), 8'h5A, 1'b1, w);
            serve_cmd($sformatf("t4_h%0d", i), (i == 23) ? 8'hA5 : 8'h5A, 1'b1, w);
        end
        check("t4_handshakes", hs_cnt - hs0, 48);
        check("t4_busy_done", {31'd0, tour_busy}, 32'd0);
        check("t4_idx_done", {27'd0, mv_indx}, 32'd0);
        check("t5_no_ack", uart_ack_busy, 0);
        check("t5_no_fwd", uart_fwd_busy, 0);
        check("t5_fwd_cmd", {16'd0, cmd}, 32'h5555);
        check("t5_fwd_rdy", {31'd0, cmd_rdy}, 32'd1);
        clr_cmd_rdy = 1'b1;
        #1;
        check("t5_ack", {31'd0, clr_cmd_rdy_UART}, 32'd1);
        tick();
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;

        // Reset abort in WAIT_H at index 7
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exp_v[bit_of[i]]);
            exp_q.push_back(exp_h[bit_of[i]]);
        end
        start();
        for (int i = 0; i < 8; i++) begin
            serve_cmd($sformatf("t6_v%0d", i), 8'h5A, 1'b1, w);
            serve_cmd($sformatf("t6_h%0d", i), 8'h5A, (i != 7), w);
        end
        check("t6_pre_state", {29'd0, state_dbg}, 32'd4);
        check("t6_pre_idx", {27'd0, mv_indx}, 32'd7);
        cmd_UART = 16'h1111;
        cmd_rdy_UART = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t6_state", {29'd0, state_dbg}, 32'd0);
        check("t6_idx", {27'd0, mv_indx}, 32'd0);
        check("t6_busy", {31'd0, tour_busy}, 32'd0);
        check("t6_rdy_follow", {31'd0, cmd_rdy}, 32'd1);
        check("t6_cmd_follow", {16'd0, cmd}, 32'h1111);
        tick();
        rst_n = 1'b1;
        cmd_rdy_UART = 1'b0;
        tick();
        exp_q.delete();
        exp_q.push_back(exp_v[bit_of[0]]);
        start();
        check("t6_restart_idx", {27'd0, mv_indx}, 32'd0);
        serve_cmd("t6_restart_v", 8'h5A, 1'b1, w);
        check("t6_restart_latency", w, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
